spike_gen_scheduler: RTL and testbench
======================================

# spike_gen_scheduler

Time-multiplexed controller for the FPGA spike generators. It holds per-generator programming (period, countdown, tag, sign) written through the generator programming channel. On every wall-clock time-unit pulse it sequences through generators 0..gens_used and emits one tag/count word per firing generator onto a TagCt output channel that feeds the tag merge toward BD. It sits between the time manager (time-unit pulse), the register bank (generator conf), the PC-side decoder (programming words) and the downstream tag path.

## Interface
Parameters:
- Ngens, 8: generator index width; 2**Ngens generator slots.
- Nperiod, 16: period/countdown width.
- Ntag, 11: tag width.
- Nct, 9: output count width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- time_unit  in  1  single-cycle pulse, one per wall-clock time unit.
- gens_used  in  Ngens  highest generator index to scan (SpikeGeneratorConf).
- gens_en  in  2**Ngens  per-generator enable (SpikeGeneratorConf).
- prog_gen_idx  in  Ngens  generator being programmed.
- prog_period  in  Nperiod  firing period in time units; 0 disables the generator.
- prog_ticks  in  Nperiod  initial countdown.
- prog_tag  in  Ntag  tag emitted on firing.
- prog_sign  in  1  0 selects count +1, 1 selects count -1.
- prog_v  in  1  programming word valid.
- prog_a  out  1  programming word accepted.
- out_tag  out  Ntag  emitted tag.
- out_ct  out  Nct  emitted count: 1 for sign 0, all-ones (-1) for sign 1.
- out_v  out  1  output valid.
- out_a  in  1  output accept.
- tick_overrun  out  1  one-cycle pulse when a time_unit is dropped.

## Operation
- State per slot: period, ticks, tag, sign. Reset clears every field to 0, so all slots start inactive.
- FSM states:
  - IDLE: on time_unit, or with pending set, latch scan_max <= gens_used, set idx <= 0, clear pending, go to SCAN.
  - SCAN: evaluate slot idx. The slot is active when gens_en[idx]=1 and period!=0.
    - Active with ticks==0: reload ticks <= period-1, load out_tag/out_ct, set out_v, go to EMIT.
    - Active with ticks!=0: ticks <= ticks-1.
    - Inactive: no change.
    - In the non-emit cases: if idx==scan_max go to IDLE, else idx <= idx+1.
  - EMIT: hold out_tag, out_ct and out_v=1 until out_a=1. On the handshake cycle, drop out_v. Then go to IDLE if idx==scan_max, else set idx <= idx+1 and go to SCAN.
- Programming:
  - prog_a = prog_v & (state==IDLE) & ~time_unit & ~pending. This path is combinational.
  - On acceptance, write all four fields of slot prog_gen_idx. prog_ticks is loaded as given, not masked against period.
- Pending ticks:
  - time_unit while not in IDLE sets pending (one deep).
  - time_unit while pending is already set leaves pending set and pulses tick_overrun for 1 cycle.
- Firing cadence: a slot with period P fires every P time units after its initial countdown. P=1 fires every unit.
- gens_used is sampled at scan start; gens_en is read live at evaluation.
- A slot index above gens_used is never evaluated, and its state is frozen.

## Timing
- Reset values: state=IDLE, idx=0, pending=0, out_v=0, out_tag=0, out_ct=0, prog_a=0, tick_overrun=0.
- Scan start: time_unit in cycle t gives SCAN of idx 0 in cycle t+1.
- Per-slot cost: each non-firing slot takes 1 cycle. A firing slot takes 1 SCAN cycle plus at least 1 EMIT cycle.
- Output latency: out_v rises the cycle after the firing slot's SCAN cycle.
- Output handshake:
  - out_v, once high, stays high with stable data until out_a.
  - The transfer completes on the cycle out_v & out_a are both 1.
  - out_v is never asserted back-to-back without an intervening SCAN cycle.
- Minimum scan length: gens_used+1 cycles with no firings.
- Simultaneous time_unit and prog_v in IDLE: the tick wins; prog_a=0 and programming waits until the scan ends.
- Reset asserted mid-scan or mid-EMIT: immediate return to reset values. The pending output word is lost, and all slot programming is cleared.

## Test plan
- Program slot 3 with period=4, ticks=0, tag=0x2A, sign=0; set gens_used=3, gens_en[3]=1; apply 8 time_units -> words (0x2A, ct=1) on units 1 and 5 only.
- Program slot 0 with period=1, sign=1, tag=0x7FF; hold out_a=0 for 10 cycles after out_v -> out_v and data stable throughout; out_ct=0x1FF; exactly one transfer when out_a rises.
- Program slots 0..5 all with period=1; set gens_used=5; issue one time_unit with out_a held at 1 -> six words in idx order; scan returns to IDLE within 1+6*2 cycles.
- Issue time_unit, then 2 more time_units during a stalled EMIT -> pending serves one extra scan; tick_overrun pulses exactly once.
- Assert prog_v in the same cycle as time_unit -> prog_a=0 until the scan completes, then accepted in IDLE. Program slot 9 with gens_used=8 -> slot 9 never emits.
- Assert reset_n low during EMIT -> out_v=0 the same cycle. After release, no words are emitted on subsequent time_units until slots are reprogrammed.

Source files
------------

// File: rtl/spike_gen_scheduler.sv
// Time-multiplexed spike generator scheduler: scans generator slots on each
// time-unit pulse and emits one tag/count word per firing slot.

module spike_gen_slot #(
  parameter int Nperiod = 16,
  parameter int Ntag    = 11
)(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_wr,
  input  logic [Nperiod-1:0] i_period,
  input  logic [Nperiod-1:0] i_ticks,
  input  logic [Ntag-1:0]    i_tag,
  input  logic               i_sign,
  input  logic               i_upd,
  input  logic [Nperiod-1:0] i_ticks_nxt,
  output logic [Nperiod-1:0] o_period,
  output logic [Nperiod-1:0] o_ticks,
  output logic [Ntag-1:0]    o_tag,
  output logic               o_sign
);
  logic [Nperiod-1:0] r_period, r_ticks;
  logic [Ntag-1:0]    r_tag;
  logic               r_sign;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period <= '0;
      r_ticks  <= '0;
      r_tag    <= '0;
      r_sign   <= 1'b0;
    end else if (i_wr) begin
      r_period <= i_period;
      r_ticks  <= i_ticks;
      r_tag    <= i_tag;
      r_sign   <= i_sign;
    end else if (i_upd) begin
      r_ticks  <= i_ticks_nxt;
    end
  end

  assign o_period = r_period;
  assign o_ticks  = r_ticks;
  assign o_tag    = r_tag;
  assign o_sign   = r_sign;
endmodule

module spike_gen_scheduler #(
  parameter int Ngens   = 8,
  parameter int Nperiod = 16,
  parameter int Ntag    = 11,
  parameter int Nct     = 9
)(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  time_unit,
  input  logic [Ngens-1:0]      gens_used,
  input  logic [2**Ngens-1:0]   gens_en,
  input  logic [Ngens-1:0]      prog_gen_idx,
  input  logic [Nperiod-1:0]    prog_period,
  input  logic [Nperiod-1:0]    prog_ticks,
  input  logic [Ntag-1:0]       prog_tag,
  input  logic                  prog_sign,
  input  logic                  prog_v,
  output logic                  prog_a,
  output logic [Ntag-1:0]       out_tag,
  output logic [Nct-1:0]        out_ct,
  output logic                  out_v,
  input  logic                  out_a,
  output logic                  tick_overrun
);
  localparam int NSLOTS = 2**Ngens;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT} state_t;

  state_t             r_state, w_state_nxt;
  logic [Ngens-1:0]   r_idx, r_scan_max;
  logic               r_pending, r_overrun;
  logic [Ntag-1:0]    r_out_tag;
  logic [Nct-1:0]     r_out_ct;
  logic               r_out_v;

  logic [NSLOTS-1:0][Nperiod-1:0] w_period_a, w_ticks_a;
  logic [NSLOTS-1:0][Ntag-1:0]    w_tag_a;
  logic [NSLOTS-1:0]              w_sign_a;

  logic [Nperiod-1:0] w_cur_period, w_cur_ticks, w_ticks_nxt;
  logic [Ntag-1:0]    w_cur_tag;
  logic               w_cur_sign;
  logic               w_active, w_fire, w_last, w_hs, w_prog_acc;
  logic               w_start, w_idx_inc, w_emit_ld, w_emit_clr, w_upd;

  assign w_cur_period = w_period_a[r_idx];
  assign w_cur_ticks  = w_ticks_a[r_idx];
  assign w_cur_tag    = w_tag_a[r_idx];
  assign w_cur_sign   = w_sign_a[r_idx];

  // gens_en is read live; the slot counts down to 0, fires, then reloads period-1
  assign w_active    = gens_en[r_idx] & (w_cur_period != '0);
  assign w_fire      = w_active & (w_cur_ticks == '0);
  assign w_ticks_nxt = (w_cur_ticks == '0) ? w_cur_period - Nperiod'(1)
                                           : w_cur_ticks - Nperiod'(1);
  assign w_last      = (r_idx == r_scan_max);
  assign w_hs        = r_out_v & out_a;
  assign w_prog_acc  = reset_n & prog_v & (r_state == S_IDLE) & ~time_unit & ~r_pending;

  for (genvar g = 0; g < NSLOTS; g++) begin : g_slot
    spike_gen_slot #(.Nperiod(Nperiod), .Ntag(Ntag)) u_slot (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_wr        (w_prog_acc && (prog_gen_idx == Ngens'(g))),
      .i_period    (prog_period),
      .i_ticks     (prog_ticks),
      .i_tag       (prog_tag),
      .i_sign      (prog_sign),
      .i_upd       (w_upd && (r_idx == Ngens'(g))),
      .i_ticks_nxt (w_ticks_nxt),
      .o_period    (w_period_a[g]),
      .o_ticks     (w_ticks_a[g]),
      .o_tag       (w_tag_a[g]),
      .o_sign      (w_sign_a[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (time_unit | r_pending) w_state_nxt = S_SCAN;
      S_SCAN:  if (w_fire)                w_state_nxt = S_EMIT;
               else if (w_last)           w_state_nxt = S_IDLE;
      S_EMIT:  if (w_hs)                  w_state_nxt = w_last ? S_IDLE : S_SCAN;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_start    = 1'b0;
    w_idx_inc  = 1'b0;
    w_emit_ld  = 1'b0;
    w_emit_clr = 1'b0;
    w_upd      = 1'b0;
    case (r_state)
      S_IDLE: w_start = time_unit | r_pending;
      S_SCAN: begin
        w_upd     = w_active;
        w_emit_ld = w_fire;
        w_idx_inc = ~w_fire & ~w_last;
      end
      S_EMIT: begin
        w_emit_clr = w_hs;
        w_idx_inc  = w_hs & ~w_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx      <= '0;
      r_scan_max <= '0;
    end else if (w_start) begin
      r_idx      <= '0;
      r_scan_max <= gens_used;
    end else if (w_idx_inc) begin
      r_idx      <= r_idx + Ngens'(1);
    end
  end

  // One-deep tick queue; a tick arriving as a pending one is consumed in IDLE stays queued
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= time_unit & r_pending & (r_state != S_IDLE);
      if (w_start)                            r_pending <= r_pending & time_unit;
      else if (time_unit && r_state != S_IDLE) r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_tag <= '0;
      r_out_ct  <= '0;
      r_out_v   <= 1'b0;
    end else if (w_emit_ld) begin
      r_out_tag <= w_cur_tag;
      r_out_ct  <= w_cur_sign ? {Nct{1'b1}} : Nct'(1);
      r_out_v   <= 1'b1;
    end else if (w_emit_clr) begin
      r_out_v   <= 1'b0;
    end
  end

  assign prog_a       = w_prog_acc;
  assign out_tag      = r_out_tag;
  assign out_ct       = r_out_ct;
  assign out_v        = r_out_v;
  assign tick_overrun = r_overrun;
endmodule

// File: tb/tb_spike_gen_scheduler.sv
// Bench for spike_gen_scheduler: vector tables, directed corner sequences and
// randomized scans against a per-slot countdown model with a word scoreboard.

module tb_spike_gen_scheduler;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         time_unit;
  logic [7:0]   gens_used;
  logic [255:0] gens_en;
  logic [7:0]   prog_gen_idx;
  logic [15:0]  prog_period, prog_ticks;
  logic [10:0]  prog_tag;
  logic         prog_sign, prog_v, prog_a;
  logic [10:0]  out_tag;
  logic [8:0]   out_ct;
  logic         out_v, out_a, tick_overrun;

  spike_gen_scheduler dut (
    .clk(clk), .reset_n(reset_n), .time_unit(time_unit),
    .gens_used(gens_used), .gens_en(gens_en),
    .prog_gen_idx(prog_gen_idx), .prog_period(prog_period), .prog_ticks(prog_ticks),
    .prog_tag(prog_tag), .prog_sign(prog_sign), .prog_v(prog_v), .prog_a(prog_a),
    .out_tag(out_tag), .out_ct(out_ct), .out_v(out_v), .out_a(out_a),
    .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int xfers = 0, ovr_cnt = 0;
  logic [10:0] last_tag;
  logic [8:0]  last_ct;
  bit sb_on = 0;

  typedef struct { logic [10:0] tag; logic [8:0] ct; } word_t;
  word_t q[$];

  logic [15:0] m_per[256], m_tk[256];
  logic [10:0] m_tag[256];
  bit          m_sign[256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: transfers complete at the next posedge when out_v & out_a are seen here
  bit prev_hold = 0;
  logic [10:0] prev_tag;
  logic [8:0]  prev_ct;
  always @(negedge clk) begin
    if (!reset_n) prev_hold = 0;
    else begin
      if (prev_hold) chk("hold_stable", {out_v, out_tag, out_ct}, {1'b1, prev_tag, prev_ct});
      if (out_v && out_a) begin
        xfers++;
        last_tag = out_tag;
        last_ct  = out_ct;
        if (sb_on) begin
          if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_unexpected: got tag 0x%0h ct 0x%0h, none required", out_tag, out_ct);
          end else begin
            word_t w;
            w = q.pop_front();
            chk("sb_tag", 32'(out_tag), 32'(w.tag));
            chk("sb_ct", 32'(out_ct), 32'(w.ct));
          end
        end
      end
      prev_hold = out_v && !out_a;
      prev_tag  = out_tag;
      prev_ct   = out_ct;
      if (tick_overrun) ovr_cnt++;
    end
  end

  // One time unit of the model: every enabled, programmed slot up to gens_used counts down
  task automatic model_tick();
    for (int i = 0; i <= int'(gens_used); i++) begin
      if (gens_en[i] && m_per[i] != 0) begin
        if (m_tk[i] == 0) begin
          q.push_back('{m_tag[i], m_sign[i] ? 9'h1FF : 9'h001});
          m_tk[i] = m_per[i] - 16'd1;
        end else m_tk[i] = m_tk[i] - 16'd1;
      end
    end
  endtask

  task automatic run_cycles(input int n, input bit rnd);
    repeat (n) begin
      @(posedge clk); #1;
      if (rnd) out_a = 1'($urandom % 2);
    end
  endtask

  task automatic do_reset();
    reset_n = 0; time_unit = 0; prog_v = 0; out_a = 0;
    for (int i = 0; i < 256; i++) begin
      m_per[i] = 0; m_tk[i] = 0; m_tag[i] = 0; m_sign[i] = 0;
    end
    q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic tick();
    if (sb_on) model_tick();
    time_unit = 1;
    @(posedge clk); #1 time_unit = 0;
  endtask

  task automatic prog(input int idx, input int per, input int tk, input int tag, input bit sg);
    int n = 0;
    prog_gen_idx = 8'(idx); prog_period = 16'(per); prog_ticks = 16'(tk);
    prog_tag = 11'(tag); prog_sign = sg; prog_v = 1;
    #1;
    while (!prog_a && n < 100) begin @(posedge clk); #1; n++; end
    if (!prog_a) begin n_chk++; n_fail++; $display("FAIL prog_timeout: got prog_a 0 required 1"); end
    @(posedge clk); #1 prog_v = 0;
    m_per[idx] = 16'(per); m_tk[idx] = 16'(tk); m_tag[idx] = 11'(tag); m_sign[idx] = sg;
  endtask

  typedef struct { logic [15:0] per; logic [15:0] tk; logic [10:0] tag; bit sg; bit en;
                   logic [7:0] mask; logic [8:0] ct; } fire_vec_t;
  typedef struct { bit pv; bit tu; bit exp_a; } proga_vec_t;

  initial begin #500000; $display("FAIL watchdog: got timeout required finish"); $fatal(1); end

  initial begin
    fire_vec_t  fv[6];
    proga_vec_t pv[4];
    int n, x0, o0;

    fv[0] = '{16'd4, 16'd0, 11'h02A, 1'b0, 1'b1, 8'h11, 9'h001};
    fv[1] = '{16'd1, 16'd0, 11'h155, 1'b1, 1'b1, 8'hFF, 9'h1FF};
    fv[2] = '{16'd3, 16'd2, 11'h001, 1'b0, 1'b1, 8'h24, 9'h001};
    fv[3] = '{16'd0, 16'd0, 11'h3FF, 1'b0, 1'b1, 8'h00, 9'h001};
    fv[4] = '{16'd2, 16'd5, 11'h0F0, 1'b1, 1'b1, 8'hA0, 9'h1FF};
    fv[5] = '{16'd1, 16'd0, 11'h02A, 1'b0, 1'b0, 8'h00, 9'h001};
    pv[0] = '{1'b0, 1'b0, 1'b0};
    pv[1] = '{1'b1, 1'b0, 1'b1};
    pv[2] = '{1'b1, 1'b1, 1'b0};
    pv[3] = '{1'b0, 1'b1, 1'b0};

    reset_n = 0; time_unit = 0; out_a = 0; gens_used = 0; gens_en = '0;
    prog_gen_idx = 0; prog_period = 0; prog_ticks = 0; prog_tag = 0; prog_sign = 0; prog_v = 1;
    #2;
    chk("rst_out_v", 32'(out_v), 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    chk("rst_out_ct", 32'(out_ct), 0);
    chk("rst_prog_a", 32'(prog_a), 0);
    chk("rst_overrun", 32'(tick_overrun), 0);
    do_reset();

    // prog_a is combinational; pulses are withdrawn before the edge so nothing is captured
    foreach (pv[i]) begin
      prog_v = pv[i].pv; time_unit = pv[i].tu;
      #2 chk($sformatf("prog_a_v%0d", i), 32'(prog_a), 32'(pv[i].exp_a));
      #1 prog_v = 0; time_unit = 0;
      @(posedge clk); #1;
    end

    foreach (fv[r]) begin
      do_reset();
      gens_used = 8'd3; gens_en = '0; gens_en[3] = fv[r].en; out_a = 1;
      prog(3, int'(fv[r].per), int'(fv[r].tk), int'(fv[r].tag), fv[r].sg);
      for (int u = 0; u < 8; u++) begin
        x0 = xfers;
        tick();
        run_cycles(10, 0);
        chk($sformatf("fire_r%0d_u%0d", r, u + 1), 32'(xfers - x0), 32'(fv[r].mask[u]));
        if (fv[r].mask[u] && xfers != x0) begin
          chk($sformatf("tag_r%0d", r), 32'(last_tag), 32'(fv[r].tag));
          chk($sformatf("ct_r%0d", r), 32'(last_ct), 32'(fv[r].ct));
        end
      end
    end

    // Stalled output holds data until accepted, then exactly one transfer
    do_reset();
    gens_used = 0; gens_en = '0; gens_en[0] = 1;
    prog(0, 1, 0, 'h7FF, 1);
    tick();
    n = 0;
    while (!out_v && n < 10) begin run_cycles(1, 0); n++; end
    chk("stall_out_v_rise", 32'(n), 1);
    for (int c = 0; c < 10; c++) begin
      chk("stall_v", 32'(out_v), 1);
      chk("stall_tag", 32'(out_tag), 32'h7FF);
      chk("stall_ct", 32'(out_ct), 32'h1FF);
      run_cycles(1, 0);
    end
    x0 = xfers;
    out_a = 1; run_cycles(1, 0); out_a = 0;
    run_cycles(10, 0);
    chk("stall_one_xfer", 32'(xfers - x0), 1);
    chk("stall_v_low", 32'(out_v), 0);

    // Six firing slots in index order, scan bounded by 1+6*2 cycles
    do_reset();
    sb_on = 1; gens_used = 5; gens_en = '1; out_a = 1;
    for (int i = 0; i < 6; i++) prog(i, 1, 0, 'h10 + i, 1'(i % 2));
    prog_gen_idx = 8'd200; prog_period = 0; prog_ticks = 0; prog_v = 1;
    x0 = xfers;
    model_tick();
    time_unit = 1;
    #1 chk("six_prog_a_tick", 32'(prog_a), 0);
    @(posedge clk); #1 time_unit = 0;
    n = 0;
    while (!prog_a && n < 40) begin run_cycles(1, 0); n++; end
    chk("six_scan_bound", 32'(n <= 12), 1);
    prog_v = 0;
    run_cycles(2, 0);
    chk("six_words", 32'(xfers - x0), 6);
    chk("six_sb_empty", 32'(q.size()), 0);
    sb_on = 0;

    // Two ticks during a stalled EMIT: one is queued, the other is dropped
    do_reset();
    gens_used = 0; gens_en = '0; gens_en[0] = 1;
    prog(0, 1, 0, 'h55, 0);
    x0 = xfers; o0 = ovr_cnt;
    tick(); run_cycles(3, 0);
    tick(); run_cycles(2, 0);
    tick(); run_cycles(3, 0);
    chk("overrun_once", 32'(ovr_cnt - o0), 1);
    out_a = 1; run_cycles(20, 0);
    chk("pending_xfers", 32'(xfers - x0), 2);
    chk("overrun_still_once", 32'(ovr_cnt - o0), 1);

    // Programming collides with a tick, then slot 9 sits above gens_used
    do_reset();
    gens_used = 8; gens_en = '1; out_a = 1;
    prog_gen_idx = 8'd9; prog_period = 16'd1; prog_ticks = 0; prog_tag = 11'h099; prog_sign = 0;
    prog_v = 1; time_unit = 1;
    #1 chk("prog_vs_tick", 32'(prog_a), 0);
    @(posedge clk); #1 time_unit = 0;
    n = 0;
    while (!prog_a && n < 50) begin run_cycles(1, 0); n++; end
    chk("min_scan_len", 32'(n), 9);
    @(posedge clk); #1 prog_v = 0;
    x0 = xfers;
    repeat (3) begin tick(); run_cycles(15, 0); end
    chk("slot9_frozen", 32'(xfers - x0), 0);
    gens_used = 9;
    tick(); run_cycles(15, 0);
    chk("slot9_reachable", 32'(xfers - x0), 1);
    chk("slot9_tag", 32'(last_tag), 32'h099);

    // Reset during EMIT drops the word and clears programming
    do_reset();
    gens_used = 0; gens_en = '0; gens_en[0] = 1;
    prog(0, 1, 0, 'h33, 0);
    tick();
    n = 0;
    while (!out_v && n < 10) begin run_cycles(1, 0); n++; end
    chk("rst_emit_v_high", 32'(out_v), 1);
    #2 reset_n = 0;
    #1 chk("rst_emit_v", 32'(out_v), 0);
    chk("rst_emit_tag", 32'(out_tag), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1; out_a = 1;
    x0 = xfers;
    repeat (3) begin tick(); run_cycles(10, 0); end
    chk("rst_cleared_slots", 32'(xfers - x0), 0);

    // Randomized scans against the model
    do_reset();
    sb_on = 1;
    gens_used = 8'($urandom_range(0, 15));
    for (int i = 0; i < 8; i++) gens_en[i*32 +: 32] = $urandom;
    for (int i = 0; i < 16; i++)
      prog(i, $urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 2047), 1'($urandom % 2));
    for (int rd = 0; rd < 40; rd++) begin
      tick();
      n = 0;
      while (q.size() != 0 && n < 400) begin run_cycles(1, 1); n++; end
      if (q.size() != 0) begin n_chk++; n_fail++; $display("FAIL rnd_drain: got %0d words left required 0", q.size()); q.delete(); end
      run_cycles(20, 1);
      if (rd % 8 == 7) begin
        prog($urandom_range(0, 15), $urandom_range(0, 5), $urandom_range(0, 6),
             $urandom_range(0, 2047), 1'($urandom % 2));
        gens_en[15:0] = 16'($urandom);
        gens_used = 8'($urandom_range(0, 15));
      end
    end
    out_a = 1; run_cycles(30, 0);
    chk("rnd_sb_empty", 32'(q.size()), 0);
    sb_on = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
